// File: rtl/dmem_pipe_if.sv
// Data-memory bus between the memory stage (master) and dmem_pipe (slave).
//
// Handshake: the master raises REQ for one cycle per request, together with
// WE/ADDR/WDATA/BE; every request that is sampled at a rising edge is accepted
// (there is no ready/backpressure). The slave answers each request, in order,
// with a one-cycle ACK exactly RDLAT cycles later; ERR and RDATA are only
// meaningful while ACK=1 and are driven to 0 otherwise.
interface dmem_pipe_if #(
  parameter int DBITS = 32
) ();
  localparam int NBYTES = DBITS / 8;

  logic              REQ;
  logic              WE;
  logic [DBITS-1:0]  ADDR;
  logic [DBITS-1:0]  WDATA;
  logic [NBYTES-1:0] BE;
  logic [DBITS-1:0]  RDATA;
  logic              ACK;
  logic              ERR;

  modport master (
    output REQ, WE, ADDR, WDATA, BE,
    input  RDATA, ACK, ERR
  );

  modport slave (
    input  REQ, WE, ADDR, WDATA, BE,
    output RDATA, ACK, ERR
  );
endinterface

// File: rtl/dmem_pipe.sv
// Pipelined data memory: word-organised synchronous RAM with byte-lane writes,
// range/alignment checking and a fixed-latency in-order acknowledge pipeline.
// Writes commit at the accepting edge; reads capture the array word at the
// accepting edge. Both are acknowledged RDLAT cycles after acceptance.
module dmem_pipe #(
  parameter int               DBITS     = 32,
  parameter int               DMEMWORDS = 2048,
  parameter logic [DBITS-1:0] BASE      = '0,
  parameter int               RDLAT     = 1,
  parameter string            INITFILE  = "DataMem.mif"
) (
  input logic          CLK,
  input logic          RESET,
  dmem_pipe_if.slave   bus
);
  localparam int NBYTES   = DBITS / 8;
  localparam int WORDBITS = $clog2(NBYTES);
  localparam int ABITS    = $clog2(DMEMWORDS);
  // Latency is held to its legal 1..4 range so the delay line is never empty.
  localparam int LAT      = (RDLAT < 1) ? 1 : ((RDLAT > 4) ? 4 : RDLAT);
  // Span is one bit wider than the address so the strict upper bound cannot wrap.
  localparam logic [DBITS:0] SPAN = (DBITS+1)'(DMEMWORDS * NBYTES);

  // INITFILE names the image the implementation flow preloads into r_mem.

  logic [DBITS-1:0] r_mem [DMEMWORDS];

  // Delay line: index 0 is captured at the accepting edge, LAT-1 drives the bus.
  logic [LAT-1:0]   r_v;
  logic [LAT-1:0]   r_e;
  logic [DBITS-1:0] r_d [LAT];

  logic [DBITS-1:0] w_off;
  logic             w_in_range;
  logic             w_aligned;
  logic [ABITS-1:0] w_idx;
  logic             w_legal;
  logic             w_illegal;
  logic             w_do_write;

  assign w_off      = bus.ADDR - BASE;
  assign w_in_range = (bus.ADDR >= BASE) && ({1'b0, w_off} < SPAN);
  assign w_idx      = w_off[WORDBITS+ABITS-1:WORDBITS];

  // Byte-wide memories have no sub-word offset, so every address is aligned.
  if (WORDBITS > 0) begin : g_align
    assign w_aligned = (bus.ADDR[WORDBITS-1:0] == '0);
  end else begin : g_no_align
    assign w_aligned = 1'b1;
  end

  assign w_legal    = bus.REQ && w_in_range && w_aligned;
  assign w_illegal  = bus.REQ && !(w_in_range && w_aligned);
  // A request sampled together with RESET is ignored, so it must not write.
  assign w_do_write = w_legal && bus.WE && !RESET;

  // RAM write port: only the enabled byte lanes of a legal write change.
  always_ff @(posedge CLK) begin
    if (w_do_write) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (bus.BE[i]) begin
          r_mem[w_idx][8*i +: 8] <= bus.WDATA[8*i +: 8];
        end
      end
    end
  end

  // Acknowledge pipeline: capture {valid, err, data} and shift it LAT-1 stages.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_v <= '0;
      r_e <= '0;
      for (int i = 0; i < LAT; i++) begin
        r_d[i] <= '0;
      end
    end else begin
      r_v[0] <= bus.REQ;
      r_e[0] <= w_illegal;
      // Only a legal read carries data; writes and errors return zero.
      r_d[0] <= (w_legal && !bus.WE) ? r_mem[w_idx] : '0;
      for (int i = 1; i < LAT; i++) begin
        r_v[i] <= r_v[i-1];
        r_e[i] <= r_e[i-1];
        r_d[i] <= r_d[i-1];
      end
    end
  end

  assign bus.ACK   = r_v[LAT-1];
  assign bus.ERR   = r_e[LAT-1];
  assign bus.RDATA = r_d[LAT-1];
endmodule

// File: tb/tb_dmem_pipe.sv
// Bench for dmem_pipe: four instances with RDLAT = 1..4 share one request
// driver; the selected instance is stimulated and its acknowledges are checked
// against a scoreboard fed by a small reference memory model.
module tb_dmem_pipe;
  localparam int          DBITS = 32;
  localparam int          WORDS = 64;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam logic [31:0] SPAN  = WORDS * 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- shared request driver signals ----------------
  logic        req   = 1'b0;
  logic        we    = 1'b0;
  logic [31:0] addr  = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  be    = '0;
  int          sel   = 0;

  logic [3:0]  ack_v;
  logic [3:0]  err_v;
  logic [31:0] rd_v [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    dmem_pipe_if #(.DBITS(DBITS)) bus ();
    assign bus.REQ   = req && (sel == g);
    assign bus.WE    = we;
    assign bus.ADDR  = addr;
    assign bus.WDATA = wdata;
    assign bus.BE    = be;
    assign ack_v[g]  = bus.ACK;
    assign err_v[g]  = bus.ERR;
    assign rd_v[g]   = bus.RDATA;

    dmem_pipe #(
      .DBITS(DBITS), .DMEMWORDS(WORDS), .BASE(BASE),
      .RDLAT(g + 1), .INITFILE("DataMem.mif")
    ) u_dut (
      .CLK(clk), .RESET(rst), .bus(bus)
    );
  end

  // ---------------- scoreboard ----------------
  // entry = {check_data, err, data}
  logic [DBITS+1:0] exp_q[$];
  int               exp_t_q[$];
  logic [31:0]      model [4][WORDS];
  int               n_tests = 0;
  int               n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d, rdlat %0d)", tag, got, exp, cyc, sel + 1);
    end
  endtask

  // Monitor: sample away from the active edge.
  always @(negedge clk) begin
    logic [DBITS+1:0] e;
    int               t;
    if (ack_v[sel]) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_ack", 1, 0);
      end else begin
        e = exp_q.pop_front();
        t = exp_t_q.pop_front();
        chk("ack_cycle", cyc, t);
        chk("err", err_v[sel], e[DBITS]);
        if (e[DBITS+1]) chk("rdata", rd_v[sel], e[DBITS-1:0]);
      end
    end else begin
      chk("idle_outputs", {err_v[sel], rd_v[sel]}, 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_req(input bit w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, input bit track);
    bit legal;
    int idx;
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    legal = (a >= BASE) && (a < BASE + SPAN) && (a[1:0] == 2'b00);
    idx = 0;
    if (legal) idx = int'((a - BASE) >> 2);
    if (track) begin
      if (!legal) begin
        exp_q.push_back({1'b1, 1'b1, 32'h0});
      end else if (w) begin
        for (int i = 0; i < 4; i++)
          if (b[i]) model[sel][idx][8*i +: 8] = d[8*i +: 8];
        exp_q.push_back({1'b0, 1'b0, 32'h0});
      end else begin
        exp_q.push_back({1'b1, 1'b0, model[sel][idx]});
      end
      exp_t_q.push_back(cyc + sel + 1);
    end
    step(1);
    req = 1'b0; we = 1'b0; be = '0;
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 20) begin
      step(1);
      budget++;
    end
    chk("drain", exp_q.size(), 0);
    step(2);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a;
    int          kind;
    // Reset state.
    rst = 1'b1;
    step(3);
    chk("reset_ack", ack_v, 0);
    chk("reset_err", err_v, 0);
    rst = 1'b0;

    // RDLAT=1: idle, back-to-back ops, byte lanes, boundaries.
    sel = 0;
    step(4);
    do_req(1, BASE + 32'h10, 32'hDEADBEEF, 4'hF, 1);
    do_req(0, BASE + 32'h10, 32'h0, 4'h0, 1);
    do_req(1, BASE + 32'h10, 32'h000000AA, 4'b0001, 1);
    do_req(0, BASE + 32'h10, 32'h0, 4'h0, 1);
    do_req(1, BASE + 32'h10, 32'h11111111, 4'b0000, 1);
    do_req(0, BASE + 32'h10, 32'h0, 4'h0, 1);
    drain();
    chk("byte_lane_model", model[0][4], 32'hDEADBEAA);
    do_req(1, BASE + SPAN - 4, 32'hCAFEF00D, 4'hF, 1);
    do_req(0, BASE + SPAN - 4, 32'h0, 4'h0, 1);
    do_req(0, BASE + SPAN, 32'h0, 4'h0, 1);
    do_req(1, BASE, 32'h12345678, 4'hF, 1);
    do_req(1, BASE + 32'h2, 32'hFFFFFFFF, 4'hF, 1);
    do_req(0, BASE, 32'h0, 4'h0, 1);
    do_req(0, BASE - 4, 32'h0, 4'h0, 1);
    do_req(1, BASE + SPAN, 32'h0BADBAD0, 4'hF, 1);
    do_req(0, BASE + SPAN - 4, 32'h0, 4'h0, 1);
    drain();

    // RDLAT=3: four consecutive reads of words holding 1..4.
    sel = 2;
    for (int i = 0; i < 4; i++) do_req(1, BASE + 32'h20 + 4*i, i + 1, 4'hF, 1);
    drain();
    for (int i = 0; i < 4; i++) do_req(0, BASE + 32'h20 + 4*i, 32'h0, 4'h0, 1);
    drain();

    // RDLAT=4: reset kills in-flight reads and a same-edge write.
    sel = 3;
    do_req(1, BASE + 32'h40, 32'h00000055, 4'hF, 1);
    drain();
    for (int i = 0; i < 3; i++) do_req(0, BASE + 32'h40, 32'h0, 4'h0, 0);
    rst = 1'b1;
    do_req(1, BASE + 32'h40, 32'h00000BAD, 4'hF, 0);
    rst = 1'b0;
    do_req(0, BASE + 32'h40, 32'h0, 4'h0, 1);
    drain();

    // RDLAT=2: interleaved legal/illegal, then randomised traffic.
    sel = 1;
    for (int i = 0; i < WORDS; i++) do_req(1, BASE + 4*i, $urandom, 4'hF, 1);
    drain();
    do_req(0, BASE + 32'h8, 32'h0, 4'h0, 1);
    do_req(0, BASE + SPAN + 32'h40, 32'h0, 4'h0, 1);
    do_req(1, BASE + 32'hC, 32'h87654321, 4'hF, 1);
    drain();
    for (int k = 0; k < 60; k++) begin
      kind = $urandom_range(0, 9);
      a = BASE + 4 * $urandom_range(0, WORDS - 1);
      if (kind == 8) a = a + $urandom_range(1, 3);
      else if (kind == 9) a = BASE + SPAN + 4 * $urandom_range(0, 15);
      do_req(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), 1);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule
